// File: rtl/iitb_pkg.sv
// Shared definitions for the IITB pipeline: data/register geometry,
// PC register index, opcodes and the write-back FSM state type.
package iitb_pkg;

    localparam int NREG   = 8;
    localparam int DW     = 16;
    localparam int PEND_W = 2;

    localparam logic [2:0] REG_PC = 3'd7;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADI = 4'h1;
    localparam logic [3:0] OP_NDU = 4'h2;
    localparam logic [3:0] OP_LHI = 4'h3;
    localparam logic [3:0] OP_LW  = 4'h4;
    localparam logic [3:0] OP_SW  = 4'h5;
    localparam logic [3:0] OP_JAL = 4'h8;
    localparam logic [3:0] OP_JLR = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hC;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } wb_state_t;

endpackage

// File: rtl/pend_counter.sv
// Per-register pending-write counter: saturating up/down with clear.
// Simultaneous inc and dec leave the count unchanged.
// WB_BYPASS_EN adds the 'last' flag (exactly one write outstanding).
module pend_counter
    import iitb_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic full,
    output logic zero,
`ifdef WB_BYPASS_EN
    output logic last,
`endif
    output logic underflow
);

    localparam logic [PEND_W-1:0] ONE = PEND_W'(1);

    logic [PEND_W-1:0] cnt;

    assign full      = (cnt == '1);
    assign zero      = (cnt == '0);
    assign underflow = dec && zero;
`ifdef WB_BYPASS_EN
    assign last      = (cnt == ONE);
`endif

    // Count outstanding writes; saturate at both ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !dec && !full)
            cnt <= cnt + ONE;
        else if (dec && !inc && !zero)
            cnt <= cnt - ONE;
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Write-back stage: commits results to the register file, tracks pending
// writes per register for hazard queries, redirects the PC on R7 commits.
// WB_BYPASS_EN adds same-cycle forwarding of the committing result.
module wb_scoreboard #(
    parameter int NREG   = iitb_pkg::NREG,
    parameter int DW     = iitb_pkg::DW,
    parameter int PEND_W = iitb_pkg::PEND_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iss_valid,
    output logic          iss_ready,
    input  logic          iss_wen,
    input  logic [2:0]    iss_dest,
    input  logic          cm_valid,
    output logic          cm_ready,
    input  logic          cm_wen,
    input  logic [2:0]    cm_dest,
    input  logic [DW-1:0] cm_data,
    input  logic [2:0]    q_src1,
    input  logic [2:0]    q_src2,
    output logic          q_busy1,
    output logic          q_busy2,
    output logic          wr_en,
    output logic [2:0]    wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          pc_wr,
    output logic [DW-1:0] pc_data,
    output logic          flush,
    output logic [15:0]   retired,
    output logic          sb_err
`ifdef WB_BYPASS_EN
    ,
    output logic          q_fwd1,
    output logic          q_fwd2,
    output logic [DW-1:0] q_fwd_data
`endif
);

    import iitb_pkg::*;

    wb_state_t state, state_nxt;

    logic            iss_acc, cm_acc, commit_wr, pc_hit;
    logic [NREG-1:0] full, zero, undf;
`ifdef WB_BYPASS_EN
    logic [NREG-1:0] last;
`endif

    assign cm_acc    = cm_valid && cm_ready;
    assign commit_wr = cm_acc && cm_wen;
    assign pc_hit    = commit_wr && (cm_dest == REG_PC);
    assign iss_acc   = iss_valid && iss_ready && iss_wen;

    // R0..R6 are tracked; the PC slot reads as permanently idle.
    for (genvar r = 0; r < NREG-1; r++) begin : g_pend
        pend_counter #(.PEND_W(PEND_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (iss_acc && (iss_dest == 3'(r))),
            .dec       (commit_wr && (cm_dest == 3'(r))),
            .clr       (state == FLUSH),
            .full      (full[r]),
            .zero      (zero[r]),
`ifdef WB_BYPASS_EN
            .last      (last[r]),
`endif
            .underflow (undf[r])
        );
    end

    assign full[NREG-1] = 1'b0;
    assign zero[NREG-1] = 1'b1;
    assign undf[NREG-1] = 1'b0;
`ifdef WB_BYPASS_EN
    assign last[NREG-1] = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Next state and handshake readies.
    always_comb begin
        state_nxt = state;
        cm_ready  = 1'b0;
        iss_ready = 1'b0;
        case (state)
            RUN: begin
                cm_ready  = 1'b1;
                iss_ready = !(iss_wen && full[iss_dest]);
                if (cm_valid && cm_wen && (cm_dest == REG_PC))
                    state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Hazard query; with bypass, a final outstanding write that commits
    // this cycle is forwarded instead of stalling the reader.
    always_comb begin
        q_busy1 = !zero[q_src1];
        q_busy2 = !zero[q_src2];
`ifdef WB_BYPASS_EN
        q_fwd1     = commit_wr && (cm_dest == q_src1) && (q_src1 != REG_PC);
        q_fwd2     = commit_wr && (cm_dest == q_src2) && (q_src2 != REG_PC);
        q_fwd_data = cm_data;
        if (q_fwd1 && last[q_src1]) q_busy1 = 1'b0;
        if (q_fwd2 && last[q_src2]) q_busy2 = 1'b0;
`endif
    end

    // Register-file write port, PC redirect, retire count, sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            pc_wr   <= 1'b0;
            pc_data <= '0;
            flush   <= 1'b0;
            retired <= '0;
            sb_err  <= 1'b0;
        end else begin
            wr_en <= commit_wr;
            pc_wr <= pc_hit;
            flush <= pc_hit;
            if (commit_wr) begin
                wr_addr <= cm_dest;
                wr_data <= cm_data;
            end
            if (pc_hit)
                pc_data <= cm_data;
            if (cm_acc)
                retired <= retired + 16'd1;
            if (|undf)
                sb_err <= 1'b1;
        end
    end

endmodule
